// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end with an in-order memory port,
// redirect handling and a registered instruction buffer toward decode.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
//
// Handshakes: a transfer happens on a rising edge where the producer's
// valid and the consumer's ready are both high (imem_req/imem_ready for
// requests, instr_valid/instr_ready for decode). A valid, once raised, is
// not withdrawn until the transfer or a redirect/reset. imem_rvalid has
// no ready; the buffer always has room because requests are only issued
// while buffered + live in-flight entries stay below FIFO_DEPTH.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redir_valid,
    input  logic [31:0] redir_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_flushed
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int DW = PW + 4;
    localparam logic [CW:0] DEPTH_V = (CW + 1)'(FIFO_DEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] out_q, out_d;     // live in-flight requests (not marked for drop)
    logic [DW-1:0] drop_q, drop_d;   // in-flight responses to discard
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]   data_q [FIFO_DEPTH];
    logic [31:0]   pc_q [FIFO_DEPTH];

    logic          accept;
    logic          drop_rsp;
    logic          push;
    logic          pop;
    logic [CW:0]   occ;

    // Handshake decode and buffer head presentation.
    always_comb begin
        occ         = {1'b0, cnt_q} + {1'b0, out_q};
        imem_req    = !rst && !redir_valid && (occ < DEPTH_V);
        imem_addr   = fetch_pc_q;
        accept      = imem_req && imem_ready;
        drop_rsp    = imem_rvalid && (redir_valid || (drop_q != '0));
        push        = imem_rvalid && !drop_rsp;
        instr_valid = (cnt_q != '0) && !redir_valid;
        pop         = instr_valid && instr_ready;
        instr       = data_q[rd_ptr_q];
        instr_pc    = pc_q[rd_ptr_q];
    end

    // Next-state for PCs, counters and buffer pointers; a redirect overrides all.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        out_d      = out_q;
        drop_d     = drop_q;
        cnt_d      = cnt_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        if (redir_valid) begin
            fetch_pc_d = redir_pc;
            resp_pc_d  = redir_pc;
            out_d      = '0;
            drop_d     = drop_q + DW'(out_q) - DW'(imem_rvalid);
            cnt_d      = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end else begin
            if (accept) begin
                fetch_pc_d = fetch_pc_q + 32'd1;
            end
            if (push) begin
                resp_pc_d = resp_pc_q + 32'd1;
                wr_ptr_d  = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            cnt_d  = cnt_q + CW'(push) - CW'(pop);
            out_d  = out_q + CW'(accept) - CW'(imem_rvalid && (drop_q == '0));
            drop_d = drop_q - DW'(imem_rvalid && (drop_q != '0));
        end
    end

    // Control state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            out_q      <= '0;
            drop_q     <= '0;
            cnt_q      <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
            cnt_q      <= cnt_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // Buffer storage; cleared on reset so the head reads zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                data_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else if (push) begin
            data_q[wr_ptr_q] <= imem_rdata;
            pc_q[wr_ptr_q]   <= resp_pc_q;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_flushed_q;

    // Counts delivered instructions and discarded work (flushed entries + dropped responses).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched_q <= '0;
            perf_flushed_q <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_q + 32'(pop);
            perf_flushed_q <= perf_flushed_q + (redir_valid ? 32'(cnt_q) : 32'd0)
                              + 32'(drop_rsp);
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_flushed = perf_flushed_q;
`endif

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, word address of the first fetch after reset.
REQ-002 Parameter FIFO_DEPTH, default 4, instruction buffer entries; power of two, 2..16.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 imem_req  output  1  fetch request valid.
REQ-006 imem_addr  output  32  word address of request; PC counts instructions, not bytes.
REQ-007 imem_ready  input  1  memory accepts the request this cycle.
REQ-008 imem_rvalid  input  1  response valid; responses return in request order, at least 1 cycle after acceptance.
REQ-009 imem_rdata  input  32  fetched instruction word.
REQ-010 redir_valid  input  1  branch/jump redirect from execute.
REQ-011 redir_pc  input  32  redirect target word address.
REQ-012 instr_valid  output  1  instr/instr_pc valid toward the control decoder.
REQ-013 instr  output  32  instruction word, FIFO head.
REQ-014 instr_pc  output  32  word address of instr.
REQ-015 instr_ready  input  1  decoder consumes head this cycle.

Function
REQ-016 Request accepted when imem_req && imem_ready; fetch_pc increments by 1 on each acceptance, wrapping 32'hFFFF_FFFF -> 0.
REQ-017 imem_req = !redir_valid && (fifo_count + outstanding + (drop_cnt excluded)) < FIFO_DEPTH; imem_addr = fetch_pc.
REQ-018 outstanding counter: +1 on acceptance, -1 on imem_rvalid, both in one cycle -> unchanged; never exceeds FIFO_DEPTH.
REQ-019 On imem_rvalid with drop_cnt > 0: response discarded, drop_cnt decrements; no FIFO push.
REQ-020 On imem_rvalid with drop_cnt == 0: push {imem_rdata, resp_pc}; resp_pc increments by 1.
REQ-021 FIFO registered, no bypass: response pushed in cycle N appears on instr_valid in cycle N+1.
REQ-022 instr_valid = !fifo_empty && !redir_valid; pop when instr_valid && instr_ready.
REQ-023 Push and pop in same cycle: count unchanged, both performed, including when full.
REQ-024 Redirect cycle: FIFO cleared; fetch_pc <= redir_pc; resp_pc <= redir_pc; no request issued; drop_cnt <= outstanding + drop_cnt minus one if imem_rvalid that cycle (that response also discarded).
REQ-025 Redirect with zero in-flight: first request to redir_pc issued the following cycle.
REQ-026 Back-to-back redirects: last one wins; drop accounting accumulates.
REQ-027 instr, instr_pc hold the head entry while instr_valid && !instr_ready.

Reset
REQ-028 On rst: fetch_pc = resp_pc = RESET_PC; FIFO empty; outstanding = drop_cnt = 0; imem_req, instr_valid = 0; instr, instr_pc = 0.
REQ-029 Reset mid-operation discards all in-flight state; responses to pre-reset requests arriving after rst deasserts are not filtered (memory is reset by the same rst).
REQ-030 First cycle after rst deasserts: imem_req = 1, imem_addr = RESET_PC.

Configuration
REQ-031 Macro FETCH_PERF_CNT_EN defined: outputs perf_fetched[31:0] (+1 per pop) and perf_flushed[31:0] (+FIFO entries cleared + responses dropped), both reset to 0, wrapping.
REQ-032 Macro FETCH_PERF_CNT_EN undefined: neither port nor counter exists; behaviour otherwise identical.

Verification
REQ-033 Reset release, 1-cycle memory, instr_ready=1 -> addresses 0,1,2,... issued each cycle; instr_pc 0 valid 2 cycles after first request; one instr per cycle thereafter.
REQ-034 instr_ready=0 for 10 cycles, FIFO_DEPTH=4 -> exactly 4 entries buffered, imem_req drops to 0, no overflow; release -> pcs 0..3 delivered in order, no loss.
REQ-035 3-cycle memory latency, redir_valid at redir_pc=32'h40 with 2 in flight -> both stale responses dropped; next instr_pc=32'h40, then 32'h41.
REQ-036 redir_valid coincident with imem_rvalid and a pop attempt -> instr_valid=0 that cycle, response dropped, FIFO empty next cycle.
REQ-037 redir_pc=32'hFFFF_FFFF -> instr_pc sequence FFFF_FFFF, 0000_0000, 0000_0001.
REQ-038 FETCH_PERF_CNT_EN defined, 5 pops then redirect flushing 3 entries -> perf_fetched=5, perf_flushed=3.
